// File: rtl/fixed_point_requant.sv
// Streaming integer <-> Q(BITS) fixed-point requantizer for interleaved multi-channel samples.
// Two-stage pipeline with valid/ready handshake, rounding, saturation and overflow accounting.
module fixed_point_requant #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 32,
   parameter int BITS      = 10,
   parameter int CHANNELS  = 2,
   parameter int SATURATE  = 1,
   parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic [CW-1:0]        in_chan,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic [CW-1:0]        out_chan,
   output logic                 out_ovf,
   output logic [CHANNELS-1:0]  ovf_sticky,
   input  logic                 ovf_clear,
   output logic [15:0]          ovf_count
);

   localparam int EW = IN_WIDTH + BITS + 1;
   localparam int RW = ((EW > OUT_WIDTH) ? EW : OUT_WIDTH) + 1;

   localparam logic [EW-1:0]        HALF = EW'(1) << (BITS - 1);
   localparam logic signed [EW-1:0] BIAS = (EW'(1) << BITS) - EW'(1);
   localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      MODE_QUANT    = 2'd0,
      MODE_DQ_TRUNC = 2'd1,
      MODE_DQ_ROUND = 2'd2,
      MODE_PASS     = 2'd3
   } mode_e;

   logic                  adv;
   logic                  ready_en_q;

   logic                  s1_valid_q, s1_valid_d;
   logic signed [EW-1:0]  s1_x_q, s1_x_d;
   mode_e                 s1_mode_q, s1_mode_d;
   logic [CW-1:0]         s1_chan_q, s1_chan_d;
   logic                  s1_neg_q, s1_neg_d;
   logic [EW-1:0]         s1_rnd_q, s1_rnd_d;

   logic                  out_valid_q;
   logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
   logic [CW-1:0]         out_chan_q;
   logic                  out_ovf_q, out_ovf_d;

   logic [CHANNELS-1:0]   sticky_q, sticky_d;
   logic [15:0]           count_q, count_d;

   logic signed [EW-1:0]  y;
   logic signed [RW-1:0]  y_w;
   logic [EW-1:0]         rq;
   logic [EW-1:0]         mag;
   logic                  hs_ovf;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = ready_en_q && adv;

   // Stage 1: widen, capture sign and the rounding-biased magnitude
   always_comb begin
      s1_valid_d = in_valid && ready_en_q;
      s1_x_d     = {{(BITS+1){in_data[IN_WIDTH-1]}}, in_data};
      s1_mode_d  = mode_e'(in_mode);
      s1_chan_d  = in_chan;
      s1_neg_d   = in_data[IN_WIDTH-1];
      mag        = s1_neg_d ? EW'(-s1_x_d) : EW'(s1_x_d);
      s1_rnd_d   = mag + HALF;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_en_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_mode_q  <= MODE_QUANT;
         s1_chan_q  <= '0;
         s1_neg_q   <= 1'b0;
         s1_rnd_q   <= '0;
      end else begin
         ready_en_q <= 1'b1;
         if (adv) begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_mode_q  <= s1_mode_d;
            s1_chan_q  <= s1_chan_d;
            s1_neg_q   <= s1_neg_d;
            s1_rnd_q   <= s1_rnd_d;
         end
      end
   end

   // Stage 2: scale, then range-check against the signed output width
   always_comb begin
      y  = s1_x_q;
      rq = s1_rnd_q >> BITS;
      unique case (s1_mode_q)
         MODE_QUANT:    y = s1_x_q <<< BITS;
         MODE_DQ_TRUNC: y = s1_neg_q ? ((s1_x_q + BIAS) >>> BITS) : (s1_x_q >>> BITS);
         MODE_DQ_ROUND: y = s1_neg_q ? -signed'(rq) : signed'(rq);
         MODE_PASS:     y = s1_x_q;
      endcase
      y_w        = {{(RW-EW){y[EW-1]}}, y};
      out_ovf_d  = (y_w > OMAX) || (y_w < OMIN);
      out_data_d = y_w[OUT_WIDTH-1:0];
      if (SATURATE != 0) begin
         if (y_w > OMAX)      out_data_d = OMAX[OUT_WIDTH-1:0];
         else if (y_w < OMIN) out_data_d = OMIN[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s1_valid_q;
         out_data_q  <= out_data_d;
         out_chan_q  <= s1_chan_q;
         out_ovf_q   <= out_ovf_d;
      end
   end

   // A coincident overflow handshake takes priority over ovf_clear
   assign hs_ovf = out_valid_q && out_ready && out_ovf_q;

   always_comb begin
      sticky_d = ovf_clear ? '0 : sticky_q;
      count_d  = ovf_clear ? '0 : count_q;
      if (hs_ovf) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (out_chan_q == CW'(c)) sticky_d[c] = 1'b1;
         end
         if (count_d != 16'hFFFF) count_d = count_d + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sticky_q <= '0;
         count_q  <= '0;
      end else begin
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_chan   = out_chan_q;
   assign out_ovf    = out_ovf_q;
   assign ovf_sticky = sticky_q;
   assign ovf_count  = count_q;

endmodule

// File: tb/tb_fixed_point_requant.sv
// Scoreboard bench for fixed_point_requant: saturating and wrapping instances run in lockstep.
module tb_fixed_point_requant;

   localparam int W   = 32;
   localparam int CWT = 1;

   logic           clock     = 1'b0;
   logic           reset_n   = 1'b0;
   logic           in_valid  = 1'b0;
   logic           out_ready = 1'b1;
   logic           ovf_clear = 1'b0;
   logic [W-1:0]   in_data   = '0;
   logic [CWT-1:0] in_chan   = '0;
   logic [1:0]     in_mode   = '0;

   logic           in_ready, out_valid, out_ovf;
   logic [W-1:0]   out_data;
   logic [CWT-1:0] out_chan;
   logic [1:0]     ovf_sticky;
   logic [15:0]    ovf_count;

   logic           w_in_ready, w_out_valid, w_out_ovf;
   logic [W-1:0]   w_out_data;
   logic [CWT-1:0] w_out_chan;
   logic [1:0]     w_ovf_sticky;
   logic [15:0]    w_ovf_count;

   fixed_point_requant #(.IN_WIDTH(32), .OUT_WIDTH(32), .BITS(10), .CHANNELS(2), .SATURATE(1)) u_dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_chan(in_chan), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
      .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear), .ovf_count(ovf_count)
   );

   fixed_point_requant #(.IN_WIDTH(32), .OUT_WIDTH(32), .BITS(10), .CHANNELS(2), .SATURATE(0)) u_wrap (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_data(in_data), .in_chan(in_chan), .in_mode(in_mode),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_chan(w_out_chan),
      .out_ovf(w_out_ovf), .ovf_sticky(w_ovf_sticky), .ovf_clear(ovf_clear), .ovf_count(w_ovf_count)
   );

   typedef struct {
      logic [W-1:0]   sat;
      logic [W-1:0]   wrap;
      logic [CWT-1:0] chan;
      logic           ovf;
      int             cyc;
      bit             lat;
   } exp_t;

   exp_t           q[$];
   exp_t           e;
   int             errors = 0;
   int             checks = 0;
   int             cyc    = 0;
   bit             stall_seen = 1'b0;
   logic [W-1:0]   held_data;
   logic [CWT-1:0] held_chan;
   logic           held_ovf;
   bit             ir_low;
   int             wn;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per output handshake, checks stall stability
   always @(negedge clock) begin
      #2;
      if (!reset_n) begin
         stall_seen = 1'b0;
      end else if (out_valid) begin
         if (!out_ready) begin
            if (stall_seen) begin
               chk("stall_data", out_data, held_data);
               chk("stall_chan", W'(out_chan), W'(held_chan));
               chk("stall_ovf", W'(out_ovf), W'(held_ovf));
            end
            stall_seen = 1'b1;
            held_data  = out_data;
            held_chan  = out_chan;
            held_ovf   = out_ovf;
         end else begin
            stall_seen = 1'b0;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got 0x%08h expected no output", out_data);
            end else begin
               e = q.pop_front();
               chk("out_data", out_data, e.sat);
               chk("out_chan", W'(out_chan), W'(e.chan));
               chk("out_ovf", W'(out_ovf), W'(e.ovf));
               chk("wrap_valid", W'(w_out_valid), 32'd1);
               chk("wrap_data", w_out_data, e.wrap);
               chk("wrap_chan", W'(w_out_chan), W'(e.chan));
               chk("wrap_ovf", W'(w_out_ovf), W'(e.ovf));
               if (e.lat) chk("latency", W'(cyc - e.cyc), 32'd2);
            end
         end
      end
   end

   // Must be called at a negedge; returns at a negedge after the handshake
   task automatic send(input logic [1:0] m, input logic [W-1:0] d, input logic [CWT-1:0] c,
                       input logic [W-1:0] es, input logic [W-1:0] ew, input logic eo, input bit lat);
      bit   done;
      int   n;
      exp_t ee;
      done     = 1'b0;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_chan  = c;
      in_mode  = m;
      while (!done && n < 100) begin
         #1;
         if (in_ready) begin
            ee.sat  = es;
            ee.wrap = ew;
            ee.chan = c;
            ee.ovf  = eo;
            ee.cyc  = cyc;
            ee.lat  = lat;
            q.push_back(ee);
            done = 1'b1;
         end
         @(posedge clock);
         @(negedge clock);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0 for 100 cycles expected 1 (data 0x%08h)", d);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n        = 0;
      in_valid = 1'b0;
      while (q.size() != 0 && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
      @(negedge clock);
   endtask

   task automatic check_counts(input logic [1:0] es, input logic [15:0] ec);
      #3;
      chk("ovf_sticky", W'(ovf_sticky), W'(es));
      chk("ovf_count", W'(ovf_count), W'(ec));
      chk("wrap_ovf_sticky", W'(w_ovf_sticky), W'(es));
      chk("wrap_ovf_count", W'(w_ovf_count), W'(ec));
      @(negedge clock);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_out_valid", W'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_chan", W'(out_chan), 32'd0);
      chk("rst_out_ovf", W'(out_ovf), 32'd0);
      chk("rst_ovf_sticky", W'(ovf_sticky), 32'd0);
      chk("rst_ovf_count", W'(ovf_count), 32'd0);
      chk("rst_in_ready", W'(in_ready), 32'd0);
      chk("rst_wrap_in_ready", W'(w_in_ready), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("in_ready_before_clk", W'(in_ready), 32'd0);
      @(negedge clock);
      #1;
      chk("in_ready_after_clk", W'(in_ready), 32'd1);
      chk("wrap_in_ready_after_clk", W'(w_in_ready), 32'd1);
      @(negedge clock);

      // Quantize, in range
      send(2'd0, 32'd3,        1'b0, 32'h0000_0C00, 32'h0000_0C00, 1'b0, 1'b1);
      send(2'd0, 32'hFFFF_FFFB, 1'b1, 32'hFFFF_EC00, 32'hFFFF_EC00, 1'b0, 1'b1);
      drain();
      check_counts(2'b00, 16'd0);

      // Quantize overflow, both directions
      send(2'd0, 32'h0020_0000, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
      drain();
      check_counts(2'b10, 16'd1);
      send(2'd0, 32'hFFDF_FFFF, 1'b1, 32'h8000_0000, 32'h7FFF_FC00, 1'b1, 1'b1);
      drain();
      check_counts(2'b10, 16'd2);

      // Dequantize truncate / round, passthrough
      send(2'd1, 32'hFFFF_FBFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      send(2'd1, 32'd1025,      1'b1, 32'd1,         32'd1,         1'b0, 1'b1);
      send(2'd1, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'd0,         1'b0, 1'b1);
      send(2'd2, 32'd1536,      1'b1, 32'd2,         32'd2,         1'b0, 1'b1);
      send(2'd2, 32'hFFFF_FA00, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b1);
      send(2'd2, 32'd1535,      1'b1, 32'd1,         32'd1,         1'b0, 1'b1);
      send(2'd3, 32'h1234_5678, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
      send(2'd3, 32'h8000_0000, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      drain();
      check_counts(2'b10, 16'd2);

      // Backpressure: 6 back-to-back samples, 5-cycle stall after first output
      ir_low = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send(2'd3, W'(32'h100 + i), i[0], W'(32'h100 + i), W'(32'h100 + i), 1'b0, 1'b0);
            end
            in_valid = 1'b0;
         end
         begin
            wn = 0;
            #2;
            while (!out_valid && wn < 50) begin
               @(negedge clock);
               #2;
               wn++;
            end
            @(negedge clock);
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               #1;
               if (!in_ready) ir_low = 1'b1;
               @(negedge clock);
            end
            out_ready = 1'b1;
         end
      join
      chk("in_ready_drop", W'(ir_low), 32'd1);
      drain();

      // Bring count to 7
      for (int i = 0; i < 5; i++) begin
         send(2'd0, 32'h0020_0000, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
      end
      drain();
      check_counts(2'b10, 16'd7);

      // Clear coincident with an overflow handshake on channel 0
      send(2'd0, 32'h0020_0000, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
      in_valid = 1'b0;
      @(negedge clock);
      ovf_clear = 1'b1;
      #1;
      chk("clear_align_valid", W'(out_valid), 32'd1);
      @(negedge clock);
      ovf_clear = 1'b0;
      drain();
      check_counts(2'b01, 16'd1);

      // Count saturation
      for (int i = 0; i < 65540; i++) begin
         send(2'd0, 32'h0020_0000, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
      end
      drain();
      check_counts(2'b01, 16'hFFFF);

      // Asynchronous reset with two samples in flight
      out_ready = 1'b0;
      send(2'd3, 32'd11, 1'b0, 32'd11, 32'd11, 1'b0, 1'b0);
      send(2'd3, 32'd22, 1'b1, 32'd22, 32'd22, 1'b0, 1'b0);
      in_valid = 1'b0;
      #1;
      chk("pre_reset_in_ready", W'(in_ready), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_out_valid", W'(out_valid), 32'd0);
      chk("async_rst_out_data", out_data, 32'd0);
      chk("async_rst_ovf_sticky", W'(ovf_sticky), 32'd0);
      chk("async_rst_ovf_count", W'(ovf_count), 32'd0);
      q.delete();
      @(negedge clock);
      @(negedge clock);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(negedge clock);
      send(2'd3, 32'd77, 1'b0, 32'd77, 32'd77, 1'b0, 1'b1);
      drain();

      chk("queue_empty", W'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
